// File: rtl/xor_acc_pkg.sv
// Shared definitions for the XOR stream accumulator: FSM state type and
// default widths used by the accumulator top level.
package xor_acc_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/mux_xor_bit.sv
// One-bit XOR built from a 2:1 mux: the select input chooses between the
// accumulator bit and its complement, which is exactly a ^ b.
module mux_xor_bit (
    input  logic i_sel,
    input  logic i_d0,
    input  logic i_d1,
    output logic o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/xor_stream_accumulator.sv
// XOR stream accumulator: XORs every word of a packet together and counts
// the beats (saturating), then presents the result until it is consumed.
// Optional feature: define XOR_STREAM_ACCUMULATOR_PARITY_EN to add the
// out_parity output (XOR-reduction of out_data, registered with it).
module xor_stream_accumulator
    import xor_acc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
`ifdef XOR_STREAM_ACCUMULATOR_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    state_t             r_state;
    state_t             w_nextState;
    logic               w_inReady;
    logic               w_outValid;
    logic               w_accept;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_outData;
    logic [CNT_W-1:0]   r_outCount;
    logic [WIDTH-1:0]   w_xor;
    logic [CNT_W-1:0]   w_cntSat;
`ifdef XOR_STREAM_ACCUMULATOR_PARITY_EN
    logic               r_parity;
`endif

    // Per-bit XOR of the running accumulator with the incoming word.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_xorBit
            mux_xor_bit u_mux (
                .i_sel (in_data[gi]),
                .i_d0  (r_acc[gi]),
                .i_d1  (~r_acc[gi]),
                .o_y   (w_xor[gi])
            );
        end
    endgenerate

    // Beat count plus one, held at all-ones once the counter is full.
    assign w_cntSat = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // State register; reset drops any partial or pending packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and handshake outputs; ready and valid follow the state.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ACCUM: begin
                w_inReady = 1'b1;
                w_accept  = in_valid;
                if (in_valid && in_last) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                w_outValid = 1'b1;
                if (out_ready) begin
                    w_nextState = ACCUM;
                end
            end
            default: begin
                w_nextState = ACCUM;
            end
        endcase
    end

    // Accumulate on each accepted beat; the last beat loads the result
    // registers and clears the accumulator for the next packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_outData  <= '0;
            r_outCount <= '0;
        end else if (w_accept) begin
            if (in_last) begin
                r_outData  <= w_xor;
                r_outCount <= w_cntSat;
                r_acc      <= '0;
                r_cnt      <= '0;
            end else begin
                r_acc <= w_xor;
                r_cnt <= w_cntSat;
            end
        end
    end

`ifdef XOR_STREAM_ACCUMULATOR_PARITY_EN
    // Parity of the result, captured on the same edge as the result word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept && in_last) begin
            r_parity <= ^w_xor;
        end
    end

    assign out_parity = r_parity;
`endif

    assign in_ready  = w_inReady;
    assign out_valid = w_outValid;
    assign out_data  = r_outData;
    assign out_count = r_outCount;

endmodule

// File: tb/tb_xor_stream_accumulator.sv
// Self-checking bench for xor_stream_accumulator: a table of packet beats
// with expected results feeds a scoreboard queue, plus hand-written
// sequences for hold, reset and counter saturation corner cases.
// Build with XOR_STREAM_ACCUMULATOR_PARITY_EN defined to cover out_parity.
module tb_xor_stream_accumulator;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] expData;
        logic [3:0] expCount;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] count;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       inValid;
    logic       inReady;
    logic [7:0] inData;
    logic       inLast;
    logic       outValid;
    logic       outReady;
    logic [7:0] outData;
    logic [3:0] outCount;

    logic       bInValid;
    logic       bInReady;
    logic [7:0] bInData;
    logic       bInLast;
    logic       bOutValid;
    logic [7:0] bOutData;
    logic [1:0] bOutCount;

`ifdef XOR_STREAM_ACCUMULATOR_PARITY_EN
    logic       outParity;
    logic       bOutParity;
`endif

    int   checks;
    int   errors;
    exp_t expQ[$];
    vec_t vecs[12];

    xor_stream_accumulator #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .in_last   (inLast),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_count (outCount)
`ifdef XOR_STREAM_ACCUMULATOR_PARITY_EN
        ,
        .out_parity(outParity)
`endif
    );

    xor_stream_accumulator #(.WIDTH(8), .CNT_W(2)) dutSat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bInValid),
        .in_ready  (bInReady),
        .in_data   (bInData),
        .in_last   (bInLast),
        .out_valid (bOutValid),
        .out_ready (1'b1),
        .out_data  (bOutData),
        .out_count (bOutCount)
`ifdef XOR_STREAM_ACCUMULATOR_PARITY_EN
        ,
        .out_parity(bOutParity)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and wait (bounded) until it has been accepted.
    task automatic applyStimulus(input logic [7:0] d, input logic l);
        bit accepted;
        accepted = 1'b0;
        inValid  = 1'b1;
        inData   = d;
        inLast   = l;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (inReady) begin
                accepted = 1'b1;
                break;
            end
            tick();
        end
        if (accepted) begin
            tick();
        end else begin
            checkOutput("beat_accept_timeout", 32'd0, 32'd1);
        end
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    // Scoreboard: compare every consumed result against the queue head.
    always @(negedge clk) begin
        if (!rst && outValid && outReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sb_data", 32'(outData), 32'(e.data));
                checkOutput("sb_count", 32'(outCount), 32'(e.count));
`ifdef XOR_STREAM_ACCUMULATOR_PARITY_EN
                checkOutput("sb_parity", 32'(outParity), 32'(^e.data));
`endif
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        inValid  = 1'b0;
        inData   = 8'h00;
        inLast   = 1'b0;
        outReady = 1'b1;
        bInValid = 1'b0;
        bInData  = 8'h00;
        bInLast  = 1'b0;

        vecs[0]  = '{8'h3C, 1'b0, 8'h00, 4'd0};
        vecs[1]  = '{8'hA5, 1'b0, 8'h00, 4'd0};
        vecs[2]  = '{8'h0F, 1'b1, 8'h96, 4'd3};
        vecs[3]  = '{8'h5A, 1'b1, 8'h5A, 4'd1};
        vecs[4]  = '{8'hFF, 1'b0, 8'h00, 4'd0};
        vecs[5]  = '{8'h00, 1'b0, 8'h00, 4'd0};
        vecs[6]  = '{8'h80, 1'b0, 8'h00, 4'd0};
        vecs[7]  = '{8'h01, 1'b1, 8'h7E, 4'd4};
        vecs[8]  = '{8'h12, 1'b0, 8'h00, 4'd0};
        vecs[9]  = '{8'h34, 1'b1, 8'h26, 4'd2};
        vecs[10] = '{8'hC3, 1'b1, 8'hC3, 4'd1};
        vecs[11] = '{8'hAA, 1'b1, 8'hAA, 4'd1};

        // Reset state.
        #2;
        checkOutput("rst_in_ready", 32'(inReady), 32'd1);
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_out_data", 32'(outData), 32'd0);
        checkOutput("rst_out_count", 32'(outCount), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // First packet by hand: one-cycle latency and one-cycle out_valid.
        expQ.push_back('{8'h96, 4'd3});
        applyStimulus(8'h3C, 1'b0);
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h0F, 1'b1);
        @(negedge clk);
        checkOutput("p1_out_valid", 32'(outValid), 32'd1);
        checkOutput("p1_in_ready_hold", 32'(inReady), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("p1_out_valid_drop", 32'(outValid), 32'd0);
        checkOutput("p1_in_ready_back", 32'(inReady), 32'd1);
        tick();

        // Table-driven back-to-back packets with a single idle cycle.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].last) begin
                expQ.push_back('{vecs[i].expData, vecs[i].expCount});
            end
            applyStimulus(vecs[i].data, vecs[i].last);
            if (vecs[i].last) begin
                @(negedge clk);
                checkOutput("tbl_idle_in_ready", 32'(inReady), 32'd0);
                checkOutput("tbl_out_valid", 32'(outValid), 32'd1);
                tick();
            end
        end

        // Stalled result: held stable while beats offered in HOLD are ignored.
        outReady = 1'b0;
        expQ.push_back('{8'h5A, 4'd1});
        applyStimulus(8'h5A, 1'b1);
        for (int c = 0; c < 5; c++) begin
            inValid = 1'b1;
            inData  = 8'hFF;
            inLast  = 1'b1;
            @(negedge clk);
            checkOutput("hold_out_valid", 32'(outValid), 32'd1);
            checkOutput("hold_in_ready", 32'(inReady), 32'd0);
            checkOutput("hold_out_data", 32'(outData), 32'h5A);
            checkOutput("hold_out_count", 32'(outCount), 32'd1);
            tick();
        end
        inValid  = 1'b0;
        inLast   = 1'b0;
        outReady = 1'b1;
        tick();
        expQ.push_back('{8'h81, 4'd2});
        applyStimulus(8'h18, 1'b0);
        applyStimulus(8'h99, 1'b1);
        tick();

        // Reset mid-packet discards the partial packet.
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
        checkOutput("midrst_in_ready", 32'(inReady), 32'd1);
        checkOutput("midrst_out_data", 32'(outData), 32'd0);
        checkOutput("midrst_out_count", 32'(outCount), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        expQ.push_back('{8'h11, 4'd1});
        applyStimulus(8'h11, 1'b1);
        tick();

        // Reset while holding a result drops it without emitting it.
        outReady = 1'b0;
        expQ.push_back('{8'h22, 4'd1});
        applyStimulus(8'h22, 1'b1);
        @(negedge clk);
        checkOutput("holdrst_pre_valid", 32'(outValid), 32'd1);
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("holdrst_out_valid", 32'(outValid), 32'd0);
        checkOutput("holdrst_out_data", 32'(outData), 32'd0);
        tick();
        rst      = 1'b0;
        outReady = 1'b1;
        repeat (3) tick();
        expQ.push_back('{8'h33, 4'd1});
        applyStimulus(8'h33, 1'b1);
        tick();

        // Counter saturation on the 2-bit-counter instance: six beats of 0x01.
        for (int b = 0; b < 6; b++) begin
            bInValid = 1'b1;
            bInData  = 8'h01;
            bInLast  = (b == 5);
            @(negedge clk);
            checkOutput("sat_in_ready", 32'(bInReady), 32'd1);
            tick();
        end
        bInValid = 1'b0;
        bInLast  = 1'b0;
        @(negedge clk);
        checkOutput("sat_out_valid", 32'(bOutValid), 32'd1);
        checkOutput("sat_out_data", 32'(bOutData), 32'h00);
        checkOutput("sat_out_count", 32'(bOutCount), 32'd3);
`ifdef XOR_STREAM_ACCUMULATOR_PARITY_EN
        checkOutput("sat_out_parity", 32'(bOutParity), 32'd0);
`endif
        tick();

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 20 && expQ.size() != 0; w++) begin
            tick();
        end
        checkOutput("sb_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_stream_accumulator.md
XOR_STREAM_ACCUMULATOR -- requirements
Module: xor_stream_accumulator

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter CNT_W, default 4, beat-counter width in bits (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  block can accept an input beat.
REQ-007 in_data  input  WIDTH  input word.
REQ-008 in_last  input  1  marks the final beat of a packet.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  WIDTH  bitwise XOR of all words in the packet.
REQ-012 out_count  output  CNT_W  number of beats in the packet, saturating.

Function
REQ-013 The FSM SHALL have exactly two states: ACCUM and HOLD.
REQ-014 ACCUM: in_ready=1, out_valid=0; HOLD: in_ready=0, out_valid=1.
REQ-015 An input beat is accepted iff in_valid && in_ready; a result is consumed iff out_valid && out_ready.
REQ-016 On an accepted non-last beat, acc <= acc ^ in_data and cnt <= cnt+1 (saturating at 2^CNT_W-1), staying in ACCUM.
REQ-017 On an accepted last beat, out_data <= acc ^ in_data, out_count <= sat(cnt+1), acc <= 0, cnt <= 0, go to HOLD.
REQ-018 Latency: out_valid asserts on the first clk edge after the last beat is accepted (1 cycle).
REQ-019 In HOLD, out_data/out_count SHALL remain stable until consumed; in_data/in_valid are ignored.
REQ-020 Consuming in HOLD SHALL return to ACCUM on the next edge; no input beat is accepted in that same cycle.
REQ-021 Single-beat packet (in_last on first beat) SHALL yield out_data=in_data, out_count=1.
REQ-022 Counter saturation: beats beyond 2^CNT_W-1 SHALL still be XORed; out_count holds at max.
REQ-023 Per-bit XOR SHALL be built from instances of the 2:1 mux (sel=in_data bit, d0=acc bit, d1=~acc bit), not the ^ operator.

Reset
REQ-024 rst=1 SHALL immediately force state=ACCUM, acc=0, cnt=0, out_data=0, out_count=0, out_valid=0, in_ready=1 (in_ready follows state).
REQ-025 Reset asserted mid-packet or in HOLD SHALL discard the partial or pending result without emitting it.

Configuration
REQ-026 Macro XOR_STREAM_ACCUMULATOR_PARITY_EN: when defined, add output out_parity (1 bit) = XOR-reduction of out_data, registered with out_data, reset 0.
REQ-027 Without the macro, port out_parity SHALL not exist and behaviour SHALL otherwise be identical.

Structure
REQ-028 Shared package xor_acc_pkg SHALL hold the state typedef (ACCUM, HOLD) and default constants for WIDTH and CNT_W.
REQ-029 One sub-module mux_xor_bit (2:1 mux wired as a 1-bit XOR) SHALL be instantiated WIDTH times via generate.

Verification
REQ-030 Reset then beats 0x3C, 0xA5, 0x0F(last), out_ready=1 -> out_data=0x96, out_count=3, out_valid for 1 cycle.
REQ-031 Single beat 0x5A with last -> out_data=0x5A, out_count=1; with macro, out_parity=0.
REQ-032 out_ready=0 for 5 cycles in HOLD -> out_valid held, in_ready=0, data stable; beats offered during HOLD ignored.
REQ-033 CNT_W=2, 6 beats of 0x01 (last on 6th) -> out_data=0x00, out_count=3.
REQ-034 rst pulse after 2 beats of 0xFF, then 0x11(last) -> out_data=0x11, out_count=1.
REQ-035 Back-to-back packets with out_ready=1 -> one idle in_ready cycle between packets; results correct for each.
